sseg_capture: RTL and testbench

Receive-side counterpart of the four-digit multiplexed seven-segment driver. It samples the time-multiplexed anode/segment lines and recovers the four BCD digits and decimal points. Each complete refresh frame is presented as one 16-bit BCD word with a one-cycle valid strobe. It is used as an on-chip loopback monitor and bench checker for the display path.

---
 rtl/sseg_capture.sv | 187 ++++++++++++++++++
 tb/tb_sseg_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_capture.sv
// sseg_capture -- receive-side monitor for a four-digit multiplexed
// seven-segment display. It samples the active-low anode/segment lines,
// waits for each digit to be stable, decodes it to BCD and, once all four
// digits of a refresh frame have been seen, reports them as one word.
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active-low
//   an[3:0]      anode enables, active-low, an[0] = least significant digit
//   sseg[7:0]    segments, active-low, sseg[7] = dp, sseg[6:0] = {g..a}
//   dec_digits   captured BCD word, digit i in [4i+3:4i]
//   dp[3:0]      captured decimal points, active-high
//   frame_valid  one-cycle pulse when dec_digits/dp/frame_err update
//   frame_err    some digit of the reported frame was undecodable
//   stale        no digit accepted for 2^TIMEOUT_BITS-1 cycles
module sseg_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_BITS  = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an,
   input  logic [7:0]  sseg,
   output logic [15:0] dec_digits,
   output logic [3:0]  dp,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        stale
);

   localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ARM  = CW'(STABLE_CYCLES - 2);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [TIMEOUT_BITS-1:0] IDLE_MAX = {TIMEOUT_BITS{1'b1}};
   localparam logic [TIMEOUT_BITS-1:0] IDLE_ONE = TIMEOUT_BITS'(1);

   // Segment pattern to {invalid, bcd}; unknown patterns report 4'hF.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b1000000: r = {1'b0, 4'd0};
         7'b1111001: r = {1'b0, 4'd1};
         7'b0100100: r = {1'b0, 4'd2};
         7'b0110000: r = {1'b0, 4'd3};
         7'b0011001: r = {1'b0, 4'd4};
         7'b0010010: r = {1'b0, 4'd5};
         7'b0000010: r = {1'b0, 4'd6};
         7'b1111000: r = {1'b0, 4'd7};
         7'b0000000: r = {1'b0, 4'd8};
         7'b0010000: r = {1'b0, 4'd9};
         default:    r = {1'b1, 4'hF};
      endcase
      return r;
   endfunction

   // True when exactly one anode is driven (exactly one 0 bit).
   function automatic logic one_cold(input logic [3:0] a);
      logic [3:0] h;
      h = ~a;
      return (h != 4'b0000) && ((h & (h - 4'b0001)) == 4'b0000);
   endfunction

   logic [3:0]              an_m_q, an_s_q;
   logic [7:0]              sseg_m_q, sseg_s_q;
   logic [11:0]             prev_q, prev_d;
   logic [CW-1:0]           stable_cnt_q, stable_cnt_d;
   logic [3:0]              seen_q, seen_d;
   logic [15:0]             slot_q, slot_d;
   logic [3:0]              slot_dp_q, slot_dp_d;
   logic [3:0]              slot_err_q, slot_err_d;
   logic [15:0]             dec_q, dec_d;
   logic [3:0]              dp_q, dp_d;
   logic                    fv_q, fv_d;
   logic                    ferr_q, ferr_d;
   logic                    stale_q, stale_d;
   logic [TIMEOUT_BITS-1:0] idle_q, idle_d;

   logic [11:0]             sample_s;
   logic                    match_s;
   logic                    accept_s;
   logic [3:0]              wr_s;
   logic [4:0]              decoded_s;
   logic                    frame_done_s;

   // Next-state logic: stability counting, accept, slot capture, frame
   // completion and idle timeout.
   always_comb begin
      sample_s     = {an_s_q, sseg_s_q};
      match_s      = (sample_s == prev_q);
      prev_d       = sample_s;
      decoded_s    = decode_seg(sseg_s_q[6:0]);

      if (!match_s) begin
         stable_cnt_d = {CW{1'b0}};
      end else if (stable_cnt_q == CNT_MAX) begin
         stable_cnt_d = CNT_MAX;
      end else begin
         stable_cnt_d = stable_cnt_q + CNT_ONE;
      end

      // The ARM->MAX step happens once per stable run, giving one accept.
      accept_s = match_s && (stable_cnt_q == CNT_ARM) && one_cold(an_s_q);
      wr_s     = accept_s ? ~an_s_q : 4'b0000;

      for (int i = 0; i < 4; i++) begin
         slot_d[4*i +: 4] = wr_s[i] ? decoded_s[3:0] : slot_q[4*i +: 4];
         slot_dp_d[i]     = wr_s[i] ? ~sseg_s_q[7]   : slot_dp_q[i];
         slot_err_d[i]    = wr_s[i] ? decoded_s[4]   : slot_err_q[i];
      end
      seen_d = seen_q | wr_s;

      // Completion uses the slot values including the final accept, so the
      // outputs update as a whole in the cycle after that accept.
      frame_done_s = accept_s && (seen_d == 4'b1111);
      if (frame_done_s) begin
         dec_d      = slot_d;
         dp_d       = slot_dp_d;
         ferr_d     = |slot_err_d;
         fv_d       = 1'b1;
         seen_d     = 4'b0000;
         slot_err_d = 4'b0000;
      end else begin
         dec_d      = dec_q;
         dp_d       = dp_q;
         ferr_d     = ferr_q;
         fv_d       = 1'b0;
      end

      // An accept always wins over a saturated idle counter.
      if (accept_s) begin
         idle_d = {TIMEOUT_BITS{1'b0}};
      end else if (idle_q == IDLE_MAX) begin
         idle_d = IDLE_MAX;
         seen_d = 4'b0000;
      end else begin
         idle_d = idle_q + IDLE_ONE;
      end
      stale_d = (idle_d == IDLE_MAX);
   end

   // State registers, input synchronisers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_m_q       <= 4'b1111;
         an_s_q       <= 4'b1111;
         sseg_m_q     <= 8'hFF;
         sseg_s_q     <= 8'hFF;
         prev_q       <= 12'hFFF;
         stable_cnt_q <= {CW{1'b0}};
         seen_q       <= 4'b0000;
         slot_q       <= 16'h0000;
         slot_dp_q    <= 4'b0000;
         slot_err_q   <= 4'b0000;
         dec_q        <= 16'h0000;
         dp_q         <= 4'b0000;
         fv_q         <= 1'b0;
         ferr_q       <= 1'b0;
         stale_q      <= 1'b0;
         idle_q       <= {TIMEOUT_BITS{1'b0}};
      end else begin
         an_m_q       <= an;
         an_s_q       <= an_m_q;
         sseg_m_q     <= sseg;
         sseg_s_q     <= sseg_m_q;
         prev_q       <= prev_d;
         stable_cnt_q <= stable_cnt_d;
         seen_q       <= seen_d;
         slot_q       <= slot_d;
         slot_dp_q    <= slot_dp_d;
         slot_err_q   <= slot_err_d;
         dec_q        <= dec_d;
         dp_q         <= dp_d;
         fv_q         <= fv_d;
         ferr_q       <= ferr_d;
         stale_q      <= stale_d;
         idle_q       <= idle_d;
      end
   end

   assign dec_digits  = dec_q;
   assign dp          = dp_q;
   assign frame_valid = fv_q;
   assign frame_err   = ferr_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_sseg_capture.sv
module tb_sseg_capture;

   logic        clk;
   logic        reset;
   logic [3:0]  an;
   logic [7:0]  sseg;

   logic [15:0] dec_a, dec_b;
   logic [3:0]  dp_a, dp_b;
   logic        fv_a, fv_b, err_a, err_b, stale_a, stale_b;

   int n_cmp = 0;
   int n_err = 0;
   int fv_cnt_a = 0;
   int fv_cnt_b = 0;

   sseg_capture dut_a (
      .clk(clk), .reset(reset), .an(an), .sseg(sseg),
      .dec_digits(dec_a), .dp(dp_a), .frame_valid(fv_a),
      .frame_err(err_a), .stale(stale_a)
   );

   sseg_capture #(.STABLE_CYCLES(4), .TIMEOUT_BITS(6)) dut_b (
      .clk(clk), .reset(reset), .an(an), .sseg(sseg),
      .dec_digits(dec_b), .dp(dp_b), .frame_valid(fv_b),
      .frame_err(err_b), .stale(stale_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fv_a) fv_cnt_a++;
      if (fv_b) fv_cnt_b++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [15:0] vals;     // nibble F means send an undecodable pattern
      logic [3:0]  dpon;
      logic        glitch;
      logic [1:0]  gap;      // 0 none, 1 blank 1111, 2 multi-hot 1100
      logic [15:0] exp_dec;
      logic [3:0]  exp_dp;
      logic        exp_err;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic blank(input int n);
      an   = 4'b1111;
      sseg = 8'hFF;
      tick(n);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      an    = 4'b1111;
      sseg  = 8'hFF;
      tick(3);
      reset = 1'b1;
      tick(2);
   endtask

   task automatic send_digit(input int slot, input logic [3:0] val, input logic dpon,
                             input int hold, input int glitch);
      logic [6:0] seg;
      seg = enc(val);
      an  = ~(4'b0001 << slot);
      for (int g = 0; g < glitch; g++) begin
         sseg = {~dpon, seg ^ 7'(g + 1)};
         tick(1);
      end
      sseg = {~dpon, seg};
      tick(hold);
   endtask

   int base;

   initial begin
      reset = 1'b0;
      an    = 4'b1111;
      sseg  = 8'hFF;

      vecs[0] = '{vals:16'h4321, dpon:4'b0000, glitch:1'b0, gap:2'd0, exp_dec:16'h4321, exp_dp:4'b0000, exp_err:1'b0};
      vecs[1] = '{vals:16'h432F, dpon:4'b0100, glitch:1'b0, gap:2'd0, exp_dec:16'h432F, exp_dp:4'b0100, exp_err:1'b1};
      vecs[2] = '{vals:16'h6789, dpon:4'b0000, glitch:1'b0, gap:2'd0, exp_dec:16'h6789, exp_dp:4'b0000, exp_err:1'b0};
      vecs[3] = '{vals:16'h1905, dpon:4'b0000, glitch:1'b1, gap:2'd0, exp_dec:16'h1905, exp_dp:4'b0000, exp_err:1'b0};
      vecs[4] = '{vals:16'h0000, dpon:4'b1111, glitch:1'b1, gap:2'd0, exp_dec:16'h0000, exp_dp:4'b1111, exp_err:1'b0};
      vecs[5] = '{vals:16'h8642, dpon:4'b0000, glitch:1'b0, gap:2'd1, exp_dec:16'h8642, exp_dp:4'b0000, exp_err:1'b0};
      vecs[6] = '{vals:16'h1357, dpon:4'b1001, glitch:1'b0, gap:2'd2, exp_dec:16'h1357, exp_dp:4'b1001, exp_err:1'b0};
      vecs[7] = '{vals:16'hF0F0, dpon:4'b0000, glitch:1'b0, gap:2'd0, exp_dec:16'hF0F0, exp_dp:4'b0000, exp_err:1'b1};

      // Reset state.
      do_reset();
      check("reset dec", dec_a, 16'h0000);
      check("reset dp", 16'(dp_a), 16'h0000);
      check("reset fv", 16'(fv_a), 16'h0000);
      check("reset err", 16'(err_a), 16'h0000);
      check("reset stale", 16'(stale_a), 16'h0000);
      check("reset stale b", 16'(stale_b), 16'h0000);

      // Table-driven full frames.
      for (int v = 0; v < 8; v++) begin
         base = fv_cnt_a;
         for (int i = 0; i < 4; i++) begin
            send_digit(i, vecs[v].vals[4*i +: 4], vecs[v].dpon[i], 16,
                       vecs[v].glitch ? 2 : 0);
            if (i < 3 && vecs[v].gap == 2'd1) begin
               blank(100);
            end else if (i < 3 && vecs[v].gap == 2'd2) begin
               an   = 4'b1100;
               sseg = 8'h00;
               tick(100);
            end else begin
               tick(0);
            end
         end
         blank(6);
         check($sformatf("vec%0d fv count", v), 16'(fv_cnt_a - base), 16'd1);
         check($sformatf("vec%0d dec", v), dec_a, vecs[v].exp_dec);
         check($sformatf("vec%0d dp", v), 16'(dp_a), 16'(vecs[v].exp_dp));
         check($sformatf("vec%0d err", v), 16'(err_a), 16'(vecs[v].exp_err));
      end

      // A digit held only 3 cycles is never accepted.
      do_reset();
      base = fv_cnt_a;
      send_digit(0, 4'd1, 1'b0, 16, 0);
      send_digit(1, 4'd2, 1'b0, 16, 0);
      send_digit(2, 4'd3, 1'b0, 16, 0);
      send_digit(3, 4'd4, 1'b0, 3, 0);
      blank(20);
      check("short digit fv count", 16'(fv_cnt_a - base), 16'd0);
      check("short digit dec", dec_a, 16'h0000);

      // Timeout on the 6-bit instance discards the partial frame.
      do_reset();
      base = fv_cnt_b;
      send_digit(0, 4'd5, 1'b0, 16, 0);
      send_digit(1, 4'd6, 1'b0, 16, 0);
      check("stale before idle", 16'(stale_b), 16'h0000);
      blank(70);
      check("stale after idle", 16'(stale_b), 16'h0001);
      send_digit(2, 4'd2, 1'b0, 16, 0);
      check("stale cleared", 16'(stale_b), 16'h0000);
      send_digit(3, 4'd3, 1'b0, 16, 0);
      check("partial discarded", 16'(fv_cnt_b - base), 16'd0);
      check("no timeout keeps partial", dec_a, 16'h3265);
      send_digit(0, 4'd0, 1'b0, 16, 0);
      send_digit(1, 4'd1, 1'b0, 16, 0);
      blank(6);
      check("fresh frame fv count", 16'(fv_cnt_b - base), 16'd1);
      check("fresh frame dec", dec_b, 16'h3210);

      // Reset in the middle of a frame.
      send_digit(0, 4'd9, 1'b0, 16, 0);
      send_digit(1, 4'd9, 1'b0, 16, 0);
      do_reset();
      check("mid reset dec", dec_a, 16'h0000);
      base = fv_cnt_a;
      send_digit(0, 4'd5, 1'b0, 16, 0);
      send_digit(1, 4'd5, 1'b0, 16, 0);
      send_digit(2, 4'd5, 1'b0, 16, 0);
      check("after reset 3 digits dec", dec_a, 16'h0000);
      check("after reset 3 digits fv", 16'(fv_cnt_a - base), 16'd0);
      send_digit(3, 4'd5, 1'b0, 16, 0);
      blank(6);
      check("after reset fv count", 16'(fv_cnt_a - base), 16'd1);
      check("after reset dec", dec_a, 16'h5555);
      check("after reset err", 16'(err_a), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
